// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: memory geometry, release
// timing and the FSM state encoding.
package program_loader_pkg;

  localparam int ADDR_W         = 4;
  localparam int DATA_W         = 8;
  localparam int DEPTH          = 16;
  localparam int RELEASE_CYCLES = 2;
  // count must reach DEPTH, so it carries one bit more than the address.
  localparam int CNT_W          = ADDR_W + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

endpackage

// File: rtl/cpu_mem_16x8.sv
// 16x8 program memory: synchronous write, combinational read on a shared
// address. The array has no reset, so its contents survive clr_n.
// Ports: clk, we (write enable), addr, wdata, rdata (combinational).
module cpu_mem_16x8
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/program_loader.sv
// Program loader: holds a CPU in clear while a 16-byte image is streamed
// into its memory, then releases the CPU and hands it the memory port.
// Ports:
//   clk, clr_n (async active-low reset)
//   start, abort                          - load control
//   in_valid, in_data, in_ready           - image byte stream
//   cpu_read, cpu_write, cpu_address, cpu_memoryIn, cpu_memoryOut - CPU port
//   cpu_clr                               - high while the CPU is held
//   busy, done, count                     - load status
//   state                                 - registered FSM state (debug)
//
// Stream handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1; in_ready is high only in LOAD and is withdrawn in a
// cycle carrying abort, so an aborting cycle never transfers a byte.
module program_loader
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_memoryIn,
  output logic [DATA_W-1:0] cpu_memoryOut,
  output logic              cpu_clr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [1:0]        state
);

  logic [ADDR_W-1:0] ptr;
  logic [1:0]        rel_cnt;
  logic              load_accept;
  logic              in_run;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // Memory reads are unconditional in RUN, so cpu_read carries no function.
  logic              unused_cpu_read;

  assign unused_cpu_read = cpu_read;

  assign in_run      = (state == ST_RUN);
  assign in_ready    = (state == ST_LOAD) && !abort;
  assign load_accept = in_valid && in_ready;

  // Write-port mux: the loader owns the memory until RUN, then the CPU.
  assign mem_we    = load_accept || (in_run && cpu_write);
  assign mem_addr  = in_run ? cpu_address  : ptr;
  assign mem_wdata = in_run ? cpu_memoryIn : in_data;

  cpu_mem_16x8 u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Status decoded from the registered state so reset forces them directly.
  assign cpu_clr       = !in_run;
  assign busy          = (state == ST_LOAD) || (state == ST_RELEASE);
  assign done          = in_run;
  assign cpu_memoryOut = in_run ? mem_rdata : '0;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      count   <= '0;
      rel_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RUN: begin
          // abort wins over a simultaneous start.
          if (start && !abort) begin
            state <= ST_LOAD;
            ptr   <= '0;
            count <= '0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (load_accept) begin
            ptr   <= ptr + 1'b1;
            count <= count + 1'b1;
            if (ptr == ADDR_W'(DEPTH - 1)) begin
              state   <= ST_RELEASE;
              rel_cnt <= '0;
            end
          end
        end
        ST_RELEASE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (rel_cnt == 2'(RELEASE_CYCLES - 1)) begin
            state <= ST_RUN;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed loads, abort, mid-load reset and
// CPU access, with a scoreboard for stream acceptance and CPU reads.
module tb_program_loader;
  import program_loader_pkg::*;

  logic              clk;
  logic              clr_n;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_memoryIn;
  logic [DATA_W-1:0] cpu_memoryOut;
  logic              cpu_clr;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state;

  int checks;
  int failures;
  int cycles;

  // Scoreboard queues: expected CPU read data, expected count at each
  // accepted stream byte.
  logic [DATA_W-1:0] exp_q[$];
  logic [CNT_W-1:0]  cnt_q[$];

  logic [DATA_W-1:0] img_a [DEPTH];
  logic [DATA_W-1:0] img_b [DEPTH];
  logic [DATA_W-1:0] img_c [DEPTH];
  logic [DATA_W-1:0] img_d [DEPTH];
  logic [DATA_W-1:0] img   [DEPTH];

  program_loader dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .start         (start),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_memoryIn  (cpu_memoryIn),
    .cpu_memoryOut (cpu_memoryOut),
    .cpu_clr       (cpu_clr),
    .busy          (busy),
    .done          (done),
    .count         (count),
    .state         (state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations on each event.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (cnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_accept count=%0d", count);
        end else begin
          check("accept_count", 32'(count), 32'(cnt_q.pop_front()));
        end
      end
      if (cpu_read) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read data=%0h", cpu_memoryOut);
        end else begin
          check("cpu_read_data", 32'(cpu_memoryOut), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Streams the first n bytes of img; with gap=1 every byte is preceded by
  // an idle cycle. Returns the cycle count spent.
  task automatic stream(input int n, input bit gap, output int used);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 200) begin
      if (gap && (guard % 2 == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = img[i];
        cnt_q.push_back(CNT_W'(i));
        i++;
      end
      step();
      guard++;
    end
    in_valid = 1'b0;
    used = guard;
  endtask

  task automatic cpu_rd(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    cpu_read    = 1'b1;
    cpu_address = addr;
    exp_q.push_back(exp);
    step();
    cpu_read = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clr_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_address = '0;
    cpu_memoryIn = '0;
    for (int i = 0; i < DEPTH; i++) begin
      img_a[i] = 8'h20 + 8'(i);
      img_b[i] = 8'h80 + 8'(i);
      img_c[i] = 8'h40 + 8'(i);
      img_d[i] = 8'hE0 + 8'(i);
    end
    img_a[0] = 8'h17;
    img_a[1] = 8'h54;
    img_a[2] = 8'h54;
    img_a[3] = 8'h00;

    fork
      monitor();
    join_none

    // Reset state
    #12;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cpu_clr", 32'(cpu_clr), 1);
    check("rst_mem_out", 32'(cpu_memoryOut), 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("idle_hold", 32'(state), 32'(ST_IDLE));

    // start together with abort resolves as abort
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_state", 32'(state), 32'(ST_IDLE));
    check("start_abort_ready", 32'(in_ready), 0);

    // Full load, back-to-back bytes
    img = img_a;
    pulse_start();
    check("load_state", 32'(state), 32'(ST_LOAD));
    check("load_busy", 32'(busy), 1);
    stream(DEPTH, 1'b0, cycles);
    check("load_a_cycles", 32'(cycles), 16);
    check("load_a_count", 32'(count), 16);
    check("rel1_state", 32'(state), 32'(ST_RELEASE));
    check("rel1_in_ready", 32'(in_ready), 0);
    step();
    check("rel2_state", 32'(state), 32'(ST_RELEASE));
    check("rel2_cpu_clr", 32'(cpu_clr), 1);
    step();
    check("run_state", 32'(state), 32'(ST_RUN));
    check("run_done", 32'(done), 1);
    check("run_cpu_clr", 32'(cpu_clr), 0);
    check("run_busy", 32'(busy), 0);
    for (int i = 0; i < DEPTH; i++) cpu_rd(ADDR_W'(i), img_a[i]);

    // CPU write then read back, then reload from RUN
    cpu_write = 1'b1;
    cpu_address = 4'h3;
    cpu_memoryIn = 8'hA5;
    step();
    cpu_write = 1'b0;
    cpu_rd(4'h3, 8'hA5);
    pulse_start();
    check("reload_cpu_clr", 32'(cpu_clr), 1);
    check("reload_state", 32'(state), 32'(ST_LOAD));
    check("reload_count", 32'(count), 0);
    cpu_rd(4'h3, 8'h00);

    // Load with in_valid toggling
    img = img_b;
    stream(DEPTH, 1'b1, cycles);
    check("load_b_cycles", 32'(cycles), 32);
    check("load_b_count", 32'(count), 16);
    step();
    step();
    check("run_b_state", 32'(state), 32'(ST_RUN));
    for (int i = 0; i < DEPTH; i++) cpu_rd(ADDR_W'(i), img_b[i]);

    // Abort after 5 bytes
    img = img_c;
    pulse_start();
    stream(5, 1'b0, cycles);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_state", 32'(state), 32'(ST_IDLE));
    check("abort_count", 32'(count), 5);
    check("abort_cpu_clr", 32'(cpu_clr), 1);
    check("abort_busy", 32'(busy), 0);
    // Stream data offered while idle must be ignored
    in_valid = 1'b1;
    in_data = 8'hFF;
    step();
    step();
    in_valid = 1'b0;
    check("idle_valid_count", 32'(count), 5);
    for (int i = 0; i < DEPTH; i++)
      check("abort_mem", 32'(dut.u_mem.mem[i]), 32'(i < 5 ? img_c[i] : img_b[i]));

    // Reset asserted mid-load after 7 bytes
    img = img_d;
    pulse_start();
    stream(7, 1'b0, cycles);
    clr_n = 1'b0;
    #1;
    check("midrst_state", 32'(state), 32'(ST_IDLE));
    check("midrst_count", 32'(count), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_cpu_clr", 32'(cpu_clr), 1);
    step();
    clr_n = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      check("midrst_mem", 32'(dut.u_mem.mem[i]), 32'(i < 7 ? img_d[i] : img_b[i]));

    step();
    step();
    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("cnt_q_drained", 32'(cnt_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
